// File: rtl/env_frame_sync.sv
// ----------------------------------------------------------------------------
// env_frame_sync
//
// Captures one frame of envelope samples (VOICES*V_ENVS slots) from a free
// running slot generator into a working bank and, once the whole frame has
// arrived in strict order, publishes it by flipping the bank-select bit.
// A reader sees a stable, complete frame in the published bank at all times.
//
// Synchronisation uses a two-state tracker: HUNT waits for the frame marker
// on the last slot; LOCKED checks every slot against the expected index and
// drops back to HUNT (raising a sticky error) on any discontinuity.
//
// Ports
//   sCLK_XVXENVS  in   slot clock, all state on the rising edge
//   iRST          in   asynchronous active-high reset
//   xxxx          in   incoming slot index
//   n_xxxx_zero   in   frame marker, meaningful together with xxxx==LAST
//   iENV          in   envelope sample for slot xxxx
//   iRD_ADDR      in   read address into the published frame
//   iERR_CLR      in   synchronous clear of oSEQ_ERR (an error event wins)
//   oRD_DATA      out  registered read data, one cycle latency
//   oFRAME_RDY    out  one-cycle pulse after a frame is published
//   oLOCKED       out  high while the tracker is LOCKED
//   oSEQ_ERR      out  sticky sequence-error flag
//   oFRAME_CNT    out  published-frame counter, wraps at 16 bits
// ----------------------------------------------------------------------------
module env_frame_sync #(
    parameter int VOICES  = 8,
    parameter int V_ENVS  = 8,
    parameter int V_WIDTH = 3,
    parameter int E_WIDTH = 3,
    parameter int D_WIDTH = 8
) (
    input  logic                       sCLK_XVXENVS,
    input  logic                       iRST,
    input  logic [V_WIDTH+E_WIDTH-1:0] xxxx,
    input  logic                       n_xxxx_zero,
    input  logic [D_WIDTH-1:0]         iENV,
    input  logic [V_WIDTH+E_WIDTH-1:0] iRD_ADDR,
    input  logic                       iERR_CLR,
    output logic [D_WIDTH-1:0]         oRD_DATA,
    output logic                       oFRAME_RDY,
    output logic                       oLOCKED,
    output logic                       oSEQ_ERR,
    output logic [15:0]                oFRAME_CNT
);

    localparam int            SW    = V_WIDTH + E_WIDTH;
    localparam int            DEPTH = VOICES * V_ENVS;
    localparam logic [SW-1:0] LAST  = SW'(DEPTH - 1);

    typedef enum logic [0:0] {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t               state_r;
    state_t               state_next_s;
    logic [SW-1:0]        exp_r;
    logic [SW-1:0]        exp_next_s;
    logic                 pub_sel_r;
    logic                 frame_rdy_r;
    logic                 seq_err_r;
    logic [15:0]          frame_cnt_r;
    logic [D_WIDTH-1:0]   rd_data_r;

    logic                 is_last_s;
    logic                 accept_s;
    logic                 wr_en_s;
    logic                 publish_s;
    logic                 err_evt_s;

    // Both banks share one array; the MSB of the index is the bank number.
    // The published bank is pub_sel_r, the working bank is its complement.
    logic [D_WIDTH-1:0]   mem [0:(2**(SW+1))-1];

    assign is_last_s = (xxxx == LAST);
    // In order and the marker agrees with the slot position (high iff LAST).
    assign accept_s  = (xxxx == exp_r) && (n_xxxx_zero == is_last_s);

    // State register and all control/status registers.
    always_ff @(posedge sCLK_XVXENVS or posedge iRST) begin
        if (iRST) begin
            state_r     <= HUNT;
            exp_r       <= {SW{1'b0}};
            pub_sel_r   <= 1'b0;
            frame_rdy_r <= 1'b0;
            seq_err_r   <= 1'b0;
            frame_cnt_r <= 16'd0;
        end else begin
            state_r     <= state_next_s;
            exp_r       <= exp_next_s;
            frame_rdy_r <= publish_s;
            if (publish_s) begin
                pub_sel_r   <= ~pub_sel_r;
                frame_cnt_r <= frame_cnt_r + 16'd1;
            end
            // An error on the same edge as a clear keeps the flag set.
            if (err_evt_s) begin
                seq_err_r <= 1'b1;
            end else if (iERR_CLR) begin
                seq_err_r <= 1'b0;
            end
        end
    end

    // Next-state logic for the sync tracker and the expected index.
    always_comb begin
        state_next_s = state_r;
        exp_next_s   = exp_r;
        case (state_r)
            HUNT: begin
                if (is_last_s && n_xxxx_zero) begin
                    state_next_s = LOCKED;
                    exp_next_s   = {SW{1'b0}};
                end else begin
                    state_next_s = HUNT;
                end
            end
            LOCKED: begin
                if (accept_s) begin
                    state_next_s = LOCKED;
                    exp_next_s   = (exp_r == LAST) ? {SW{1'b0}} : exp_r + {{(SW-1){1'b0}}, 1'b1};
                end else begin
                    state_next_s = HUNT;
                    exp_next_s   = {SW{1'b0}};
                end
            end
            default: begin
                state_next_s = HUNT;
                exp_next_s   = {SW{1'b0}};
            end
        endcase
    end

    // Per-edge actions decoded from the current state and slot.
    always_comb begin
        wr_en_s   = 1'b0;
        publish_s = 1'b0;
        err_evt_s = 1'b0;
        case (state_r)
            HUNT: begin
                wr_en_s = 1'b0;
            end
            LOCKED: begin
                if (accept_s) begin
                    wr_en_s   = 1'b1;
                    publish_s = is_last_s;
                end else begin
                    err_evt_s = 1'b1;
                end
            end
            default: begin
                err_evt_s = 1'b0;
            end
        endcase
    end

    // Working-bank write; bank contents are intentionally not reset.
    always_ff @(posedge sCLK_XVXENVS) begin
        if (wr_en_s) begin
            mem[{~pub_sel_r, xxxx}] <= iENV;
        end
    end

    // Registered read of the published bank using the pre-edge bank select,
    // so an address presented during the oFRAME_RDY cycle sees the new frame.
    always_ff @(posedge sCLK_XVXENVS or posedge iRST) begin
        if (iRST) begin
            rd_data_r <= {D_WIDTH{1'b0}};
        end else begin
            rd_data_r <= mem[{pub_sel_r, iRD_ADDR}];
        end
    end

    assign oRD_DATA   = rd_data_r;
    assign oFRAME_RDY = frame_rdy_r;
    assign oLOCKED    = (state_r == LOCKED);
    assign oSEQ_ERR   = seq_err_r;
    assign oFRAME_CNT = frame_cnt_r;

endmodule

// File: tb/tb_env_frame_sync.sv
// ----------------------------------------------------------------------------
// tb_env_frame_sync
//
// Directed sequence of frame scenarios with random envelope data and random
// read addresses. A frame-level reference model (lock flag, expected slot,
// working/published arrays copied whole on publish) predicts every output.
// ----------------------------------------------------------------------------
module tb_env_frame_sync;

    localparam int N = 64;

    logic       clk;
    logic       rst;
    logic [5:0] xxxx;
    logic       mk;
    logic [7:0] env;
    logic [5:0] rd_addr;
    logic       err_clr;
    logic [7:0] rd_data;
    logic       frame_rdy;
    logic       locked;
    logic       seq_err;
    logic [15:0] frame_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    bit        m_locked;
    int        m_exp;
    bit        m_err;
    bit        m_rdy;
    int        m_cnt;
    bit        m_pub_valid;
    logic [7:0] m_work [N];
    logic [7:0] m_pub  [N];

    env_frame_sync dut (
        .sCLK_XVXENVS (clk),
        .iRST         (rst),
        .xxxx         (xxxx),
        .n_xxxx_zero  (mk),
        .iENV         (env),
        .iRD_ADDR     (rd_addr),
        .iERR_CLR     (err_clr),
        .oRD_DATA     (rd_data),
        .oFRAME_RDY   (frame_rdy),
        .oLOCKED      (locked),
        .oSEQ_ERR     (seq_err),
        .oFRAME_CNT   (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_locked    = 1'b0;
        m_exp       = 0;
        m_err       = 1'b0;
        m_rdy       = 1'b0;
        m_cnt       = 0;
        m_pub_valid = 1'b0;
    endtask

    task automatic check_outputs(input bit rd_chk, input logic [7:0] rd_exp);
        chk("locked", 32'(locked), 32'(m_locked));
        chk("seq_err", 32'(seq_err), 32'(m_err));
        chk("frame_rdy", 32'(frame_rdy), 32'(m_rdy));
        chk("frame_cnt", 32'(frame_cnt), 32'(m_cnt));
        if (rd_chk) chk("rd_data", 32'(rd_data), 32'(rd_exp));
    endtask

    // One slot: drive, clock, advance the model by the frame rules, compare.
    task automatic step(input int idx, input bit marker, input logic [7:0] d,
                        input int ra, input bit clr);
        bit         rd_chk;
        logic [7:0] rd_exp;
        bit         is_last;
        bit         err_now;
        xxxx    = 6'(idx);
        mk      = marker;
        env     = d;
        rd_addr = 6'(ra);
        err_clr = clr;
        rd_chk  = m_pub_valid;
        rd_exp  = m_pub[ra];
        is_last = (idx == N - 1);
        err_now = 1'b0;
        m_rdy   = 1'b0;
        @(posedge clk);
        if (!m_locked) begin
            if (is_last && marker) begin
                m_locked = 1'b1;
                m_exp    = 0;
            end
        end else if (idx == m_exp && marker == is_last) begin
            m_work[idx] = d;
            m_exp       = (m_exp + 1) % N;
            if (is_last) begin
                m_pub       = m_work;
                m_rdy       = 1'b1;
                m_cnt       = (m_cnt + 1) & 16'hFFFF;
                m_pub_valid = 1'b1;
            end
        end else begin
            err_now  = 1'b1;
            m_locked = 1'b0;
        end
        if (clr) m_err = 1'b0;
        if (err_now) m_err = 1'b1;
        #1;
        check_outputs(rd_chk, rd_exp);
        err_clr = 1'b0;
    endtask

    // Slots lo..hi with a correct marker; mode 0 -> data = slot+1, else random.
    task automatic frame(input int lo, input int hi, input int mode);
        for (int i = lo; i <= hi; i++) begin
            step(i, (i == N - 1), (mode == 0) ? 8'(i + 1) : 8'($urandom),
                 int'($urandom_range(0, N - 1)), 1'b0);
        end
    endtask

    initial begin
        int cnt_save;
        rst = 1'b1; xxxx = 6'd0; mk = 1'b0; env = 8'd0; rd_addr = 6'd0; err_clr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs(1'b1, 8'd0);
        rst = 1'b0;

        // Ideal generator, data = slot+1: lock on first LAST, publish next frame.
        frame(0, N - 1, 0);
        chk("lock_first_last", 32'(locked), 32'd1);
        frame(0, N - 1, 0);
        chk("first_rdy", 32'(frame_rdy), 32'd1);
        chk("first_cnt", 32'(frame_cnt), 32'd1);
        step(0, 1'b0, 8'($urandom), 5, 1'b0);
        chk("rd_addr5", 32'(rd_data), 32'd6);
        chk("rdy_one_cycle", 32'(frame_rdy), 32'd0);
        step(1, 1'b0, 8'($urandom), 63, 1'b0);
        chk("rd_addr63", 32'(rd_data), 32'd64);
        frame(2, N - 1, 1);
        frame(0, N - 1, 1);

        // Skip: slot 9 where 7 is expected.
        cnt_save = m_cnt;
        frame(0, 6, 1);
        step(9, 1'b0, 8'($urandom), 3, 1'b0);
        chk("skip_err", 32'(seq_err), 32'd1);
        chk("skip_unlock", 32'(locked), 32'd0);
        frame(10, N - 1, 1);
        chk("skip_cnt_same", 32'(frame_cnt), 32'(cnt_save));
        frame(0, N - 1, 1);

        // Marker dropped at LAST: error, no publish.
        cnt_save = m_cnt;
        frame(0, N - 2, 1);
        step(N - 1, 1'b0, 8'($urandom), 7, 1'b0);
        chk("nomark_rdy", 32'(frame_rdy), 32'd0);
        chk("nomark_cnt", 32'(frame_cnt), 32'(cnt_save));
        chk("nomark_err", 32'(seq_err), 32'd1);
        frame(0, N - 1, 1);

        // Marker raised at slot 20.
        frame(0, 19, 1);
        step(20, 1'b1, 8'($urandom), 8, 1'b0);
        chk("mark20_err", 32'(seq_err), 32'd1);

        // Clear alone, then clear coincident with a new error.
        step(21, 1'b0, 8'($urandom), 9, 1'b1);
        chk("clr_alone", 32'(seq_err), 32'd0);
        frame(22, N - 1, 1);
        frame(0, 9, 1);
        step(11, 1'b0, 8'($urandom), 10, 1'b1);
        chk("clr_vs_err", 32'(seq_err), 32'd1);
        frame(12, N - 1, 1);
        frame(0, N - 1, 1);

        // Counter wrap: preload 0xFFFF between edges, then one frame.
        force dut.frame_cnt_r = 16'hFFFF;
        #1;
        release dut.frame_cnt_r;
        m_cnt = 16'hFFFF;
        frame(0, N - 1, 1);
        chk("cnt_wrap", 32'(frame_cnt), 32'd0);

        // Reset asserted at slot 30 of frame 3.
        frame(0, N - 1, 1);
        frame(0, N - 1, 1);
        frame(0, N - 1, 1);
        frame(0, 29, 1);
        xxxx = 6'd30; mk = 1'b0; env = 8'($urandom);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs(1'b1, 8'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        frame(31, N - 1, 1);
        frame(0, N - 1, 1);
        chk("post_rst_cnt", 32'(frame_cnt), 32'd1);
        frame(0, N - 1, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/env_frame_sync.md
ENV_FRAME_SYNC -- requirements
Module: env_frame_sync

Interface
REQ-001 SHALL have parameter VOICES, default 8, number of voices per frame.
REQ-002 SHALL have parameter V_ENVS, default 8, envelopes per voice.
REQ-003 SHALL have parameters V_WIDTH, default 3, and E_WIDTH, default 3; slot index width is V_WIDTH+E_WIDTH; LAST = VOICES*V_ENVS-1.
REQ-004 SHALL have parameter D_WIDTH, default 8, envelope sample width.
REQ-005 SHALL have port sCLK_XVXENVS  in  1  slot clock; all state rising-edge.
REQ-006 SHALL have port iRST  in  1  asynchronous active-high reset.
REQ-007 SHALL have port xxxx  in  V_WIDTH+E_WIDTH  incoming slot index from the slot generator.
REQ-008 SHALL have port n_xxxx_zero  in  1  frame marker; valid only when sampled high on the same edge as xxxx==LAST.
REQ-009 SHALL have port iENV  in  D_WIDTH  envelope sample belonging to slot xxxx.
REQ-010 SHALL have port iRD_ADDR  in  V_WIDTH+E_WIDTH  published-frame read address.
REQ-011 SHALL have port iERR_CLR  in  1  synchronous clear of oSEQ_ERR.
REQ-012 SHALL have port oRD_DATA  out  D_WIDTH  registered read data from published bank.
REQ-013 SHALL have port oFRAME_RDY  out  1  one-cycle pulse: new frame published.
REQ-014 SHALL have port oLOCKED  out  1  high while state is LOCKED.
REQ-015 SHALL have port oSEQ_ERR  out  1  sticky sequence-error flag.
REQ-016 SHALL have port oFRAME_CNT  out  16  count of published frames, wraps 0xFFFF->0.

Function
REQ-017 SHALL hold two banks of VOICES*V_ENVS x D_WIDTH words: working bank (write) and published bank (read), selected by one toggle bit pub_sel.
REQ-018 SHALL implement states HUNT and LOCKED plus register exp (expected next index).
REQ-019 HUNT: on edge with xxxx==LAST and n_xxxx_zero=1 SHALL go LOCKED, exp<=0; no bank write in HUNT.
REQ-020 LOCKED: edge with xxxx==exp and marker consistent (marker=1 iff xxxx==LAST) SHALL write iENV to working[xxxx] and set exp<=exp+1, wrapping LAST->0.
REQ-021 LOCKED: xxxx!=exp, or marker=1 with xxxx!=LAST, or marker=0 with xxxx==LAST SHALL suppress the write, set oSEQ_ERR, go HUNT; partial frame never published.
REQ-022 Accepted write at xxxx==LAST SHALL toggle pub_sel on that edge, assert oFRAME_RDY for exactly the following cycle, increment oFRAME_CNT on that edge.
REQ-023 oRD_DATA SHALL update each edge from published[iRD_ADDR] using pub_sel value current before the edge; latency 1 cycle; address sampled during oFRAME_RDY cycle returns the new frame.
REQ-024 iERR_CLR and an error event on the same edge: set SHALL win.
REQ-025 A frame error on the LAST slot SHALL NOT toggle pub_sel, pulse oFRAME_RDY, or bump oFRAME_CNT.
REQ-026 Re-lock after error SHALL require a fresh LAST+marker edge; first full frame after re-lock is the first published.

Reset
REQ-027 iRST high SHALL asynchronously force HUNT, exp=0, pub_sel=0, oRD_DATA=0, oFRAME_RDY=0, oLOCKED=0, oSEQ_ERR=0, oFRAME_CNT=0.
REQ-028 Bank contents SHALL NOT be reset; reads before the first oFRAME_RDY are unchecked.
REQ-029 Reset asserted mid-frame SHALL discard the partial frame; after release, behaviour per REQ-019.

Verification
REQ-030 Ideal generator from reset, iENV=xxxx+1: lock at first LAST; after next full frame oFRAME_RDY one pulse, oFRAME_CNT=1, reading addr 5 returns 6, addr 63 returns 64.
REQ-031 Locked, inject xxxx=9 where exp=7 -> oSEQ_ERR=1, oLOCKED=0 next cycle, no oFRAME_RDY that frame, oFRAME_CNT unchanged.
REQ-032 Locked, marker dropped at LAST -> error, no publish; marker raised at xxxx=20 -> error.
REQ-033 iERR_CLR pulse alone -> oSEQ_ERR=0; iERR_CLR coincident with new error -> oSEQ_ERR stays 1.
REQ-034 Preload oFRAME_CNT to 0xFFFF via 65535 frames (or force) then one frame -> 0x0000.
REQ-035 iRST asserted at slot 30 of frame 3 -> all outputs zero immediately; after release, next publish carries only post-reset frame data.
